// File: rtl/pc_sequencer.sv
// Program-counter sequencer with optional MIPS-style delay slot, a queued
// redirect target, misaligned register-jump exception and a sticky halt.
module pc_sequencer #(
  parameter int          ADDR_W       = 32,
  parameter logic [63:0] RESET_VECTOR = 64'h0000_0000_BFC0_0000,
  parameter logic [63:0] EXC_VECTOR   = 64'h0000_0000_BFC0_0380,
  parameter logic [63:0] HALT_ADDR    = 64'h0,
  parameter bit          DELAY_SLOT   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              advance,
  input  logic [1:0]        kind,
  input  logic              cond,
  input  logic [15:0]       offset,
  input  logic [25:0]       instr_index,
  input  logic [ADDR_W-1:0] reg_target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] link_addr,
  output logic              jump_pending,
  output logic              halt,
  output logic              addr_error
);

  localparam logic [1:0] KIND_REL = 2'd1;
  localparam logic [1:0] KIND_ABS = 2'd2;
  localparam logic [1:0] KIND_REG = 2'd3;

  localparam logic [ADDR_W-1:0] RST_PC   = RESET_VECTOR[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] EXC_PC   = EXC_VECTOR[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] HALT_PC  = HALT_ADDR[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(64'h0FFF_FFFF);
  localparam logic [ADDR_W-1:0] LINK_INC = DELAY_SLOT ? ADDR_W'(8) : ADDR_W'(4);

  logic [ADDR_W-1:0] queue_q, queue_d, pc_d;
  logic              jp_d, halt_d, aerr_d;
  logic [ADDR_W-1:0] pc_plus4, rel_off, jump_target;
  logic              taken, misaligned, stopping;

  assign link_addr = pc + LINK_INC;

  always_comb begin
    pc_plus4    = pc + ADDR_W'(4);
    rel_off     = {{(ADDR_W-18){offset[15]}}, offset, 2'b00};
    jump_target = reg_target;
    case (kind)
      KIND_REL: jump_target = pc_plus4 + rel_off;
      KIND_ABS: jump_target = (pc_plus4 & ~LOW_MASK) | ADDR_W'({instr_index, 2'b00});
      default:  jump_target = reg_target;
    endcase
    taken      = (kind == KIND_ABS) || (kind == KIND_REG) || ((kind == KIND_REL) && cond);
    misaligned = (kind == KIND_REG) && (reg_target[1:0] != 2'b00);
    stopping   = halt || (pc == HALT_PC);

    pc_d    = pc;
    jp_d    = jump_pending;
    queue_d = queue_q;
    halt_d  = halt;
    aerr_d  = 1'b0;

    if (advance) begin
      if (stopping) begin
        // Reaching the halt address freezes everything except the sticky flag.
        halt_d = 1'b1;
      end else if (misaligned) begin
        pc_d    = EXC_PC;
        jp_d    = 1'b0;
        queue_d = '0;
        aerr_d  = 1'b1;
      end else if (DELAY_SLOT) begin
        // Old queued target wins the pc; a new redirect replaces the queue.
        pc_d = jump_pending ? queue_q : pc_plus4;
        jp_d = taken;
        if (taken) queue_d = jump_target;
      end else begin
        pc_d = taken ? jump_target : pc_plus4;
        jp_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc           <= RST_PC;
      jump_pending <= 1'b0;
      queue_q      <= '0;
      halt         <= 1'b0;
      addr_error   <= 1'b0;
    end else begin
      pc           <= pc_d;
      jump_pending <= jp_d;
      queue_q      <= queue_d;
      halt         <= halt_d;
      addr_error   <= aerr_d;
    end
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter ADDR_W, default 32, program-counter width in bits; legal range 28..64.
REQ-002 Parameter RESET_VECTOR, default 32'hBFC00000, pc value after reset; zero-extended or truncated to ADDR_W.
REQ-003 Parameter EXC_VECTOR, default 32'hBFC00380, pc value loaded on a misaligned register jump.
REQ-004 Parameter HALT_ADDR, default 0, pc value that stops the sequencer.
REQ-005 Parameter DELAY_SLOT, default 1; 1 = MIPS delay-slot mode, 0 = immediate redirect.
REQ-006 clk  input  1  clock; all state updates on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 advance  input  1  one-cycle pulse; commits the current instruction and updates pc.
REQ-009 kind  input  2  control-flow type of current instruction: 0 NONE, 1 REL (branch), 2 ABS (J/JAL), 3 REG (JR/JALR).
REQ-010 cond  input  1  branch condition; used only when kind = REL.
REQ-011 offset  input  16  signed word offset for REL.
REQ-012 instr_index  input  26  word index for ABS.
REQ-013 reg_target  input  ADDR_W  register target for REG.
REQ-014 pc  output  ADDR_W  address of the current instruction (registered).
REQ-015 link_addr  output  ADDR_W  return address: pc+8 if DELAY_SLOT = 1, else pc+4; combinational.
REQ-016 jump_pending  output  1  a redirect is queued for the next advance (registered).
REQ-017 halt  output  1  sticky stop flag (registered).
REQ-018 addr_error  output  1  one-cycle pulse on a misaligned REG target (registered).

Function
REQ-019 Inputs kind, cond, offset, instr_index and reg_target shall be sampled only in a cycle with advance = 1; in any other cycle all state shall hold.
REQ-020 A redirect is "taken" when kind = ABS, kind = REG, or kind = REL with cond = 1.
REQ-021 Targets shall be computed modulo 2^ADDR_W, as follows.
  - REL target = pc + 4 + (sign-extended offset << 2).
  - ABS target = {(pc+4)[ADDR_W-1:28], instr_index, 2'b00}.
  - REG target = reg_target.
REQ-022 The next pc (priority order) in DELAY_SLOT = 1 shall be:
  - HALT_ADDR hold if halt is set;
  - EXC_VECTOR if a REG target is misaligned;
  - the queued target if jump_pending = 1;
  - pc+4 otherwise.
  A taken redirect in the same advance shall load the queue and set jump_pending; otherwise jump_pending shall clear.
REQ-023 A taken redirect while jump_pending = 1 (branch in delay slot) shall apply the old queued target to pc and queue the new target.
REQ-024 In DELAY_SLOT = 0, a taken redirect shall load pc with its target at the same advance, and jump_pending shall remain 0.
REQ-025 An advance with kind = REG and reg_target[1:0] ≠ 0 shall trigger a misaligned-target exception.
  - pc <= EXC_VECTOR.
  - jump_pending and the queue shall be cleared.
  - addr_error shall be 1 for exactly the following cycle.
  - The exception shall take priority over the queued target.
REQ-026 An advance with pc = HALT_ADDR shall set halt.
  - Subsequent advances shall leave pc, jump_pending and the queue unchanged.
  - halt shall remain 1 until reset.
REQ-027 Latency: every pc change shall be visible one cycle after the advance edge; there shall be no combinational path from inputs to pc, jump_pending, halt or addr_error.
REQ-028 Back-to-back advance pulses in consecutive cycles shall each be honoured.

Reset
REQ-029 While reset = 1 at a clock edge, outputs shall take these values regardless of advance:
  - pc <= RESET_VECTOR;
  - jump_pending <= 0;
  - queue <= 0;
  - halt <= 0;
  - addr_error <= 0.
REQ-030 Reset asserted while a redirect is queued shall discard the redirect; the first advance after reset shall yield RESET_VECTOR+4.

Verification
REQ-031 Scenario: reset, then 3 advances with kind = NONE -> pc = BFC00000, BFC00004, BFC00008, BFC0000C.
REQ-032 Scenario: DELAY_SLOT = 1, at pc = BFC00000, advance REL with cond = 1 and offset = 3 -> pc = BFC00004 with jump_pending = 1; next advance -> pc = BFC00010 with jump_pending = 0.
REQ-033 Scenario: DELAY_SLOT = 1, at pc = BFC00010, advance REG with reg_target = 0 -> delay slot at BFC00014; next advance -> pc = 0 and halt = 0; next advance -> halt = 1; further advances -> pc stays 0.
REQ-034 Scenario: advance REG with reg_target = 80000002 -> pc = BFC00380, addr_error high for 1 cycle, jump_pending = 0.
REQ-035 Scenario: DELAY_SLOT = 0, at pc = BFC00000, advance ABS with instr_index = 0x0000100 -> pc = B0000400 on the next cycle; link_addr = pc+4.
REQ-036 Scenario: branch in delay slot, then reset asserted while jump_pending = 1 -> pc = BFC00000 and jump_pending = 0; the next advance gives pc = BFC00004.
